// File: rtl/timer_ctrl.sv
// Run/pause/clear controller: debounces the start/stop and clear buttons,
// turns accepted presses into one-cycle events and sequences the timer FSM.
module timer_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_START_STOP,
  input  logic       BTN_CLEAR,
  input  logic       TIMER_EXPIRED,
  output logic       RUN,
  output logic       CLR,
  output logic       ALARM,
  output logic [1:0] STATE
);

  localparam int unsigned NBTN = 2;
  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_CLR   = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  logic [NBTN-1:0]            raw;
  logic [NBTN-1:0]            accepted;
  logic [NBTN-1:0]            accepted_prev;
  logic [NBTN-1:0]            press_q;
  logic [NBTN-1:0][CNT_W-1:0] deb_cnt;

  state_t state_q;
  state_t next_state;
  logic   clr_next;

  assign raw = {BTN_CLEAR, BTN_START_STOP};

  // Per-button debounce: accept a new level after DEBOUNCE_CYCLES differing samples
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      accepted      <= '0;
      accepted_prev <= '0;
      press_q       <= '0;
      deb_cnt       <= '0;
    end else begin
      accepted_prev <= accepted;
      press_q       <= accepted & ~accepted_prev;
      for (int i = 0; i < int'(NBTN); i++) begin
        if (raw[i] == accepted[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          accepted[i] <= raw[i];
          deb_cnt[i]  <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // State register with registered decodes of the next state
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      RUN     <= 1'b0;
      ALARM   <= 1'b0;
      CLR     <= 1'b0;
    end else begin
      state_q <= next_state;
      RUN     <= (next_state == RUNNING);
      ALARM   <= (next_state == EXPIRED);
      CLR     <= clr_next;
    end
  end

  // Next-state logic; clear beats start everywhere, expiry beats presses in RUNNING
  always_comb begin
    next_state = state_q;
    clr_next   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_q[BTN_CLR]) begin
          clr_next = 1'b1;
        end else if (press_q[BTN_START]) begin
          next_state = RUNNING;
        end
      end
      RUNNING: begin
        if (TIMER_EXPIRED) begin
          next_state = EXPIRED;
        end else if (press_q[BTN_CLR]) begin
          next_state = IDLE;
          clr_next   = 1'b1;
        end else if (press_q[BTN_START]) begin
          next_state = PAUSED;
        end
      end
      PAUSED: begin
        if (press_q[BTN_CLR]) begin
          next_state = IDLE;
          clr_next   = 1'b1;
        end else if (press_q[BTN_START]) begin
          next_state = RUNNING;
        end
      end
      EXPIRED: begin
        if (press_q[BTN_CLR] || press_q[BTN_START]) begin
          next_state = IDLE;
          clr_next   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign STATE = 2'(state_q);

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: directed scenarios plus random button and
// expiry traffic, checked cycle by cycle against a history-based reference model.
module tb_timer_ctrl;

  localparam int D = 4;

  logic       CLK;
  logic       RST_N;
  logic       BTN_START_STOP;
  logic       BTN_CLEAR;
  logic       TIMER_EXPIRED;
  logic       RUN;
  logic       CLR;
  logic       ALARM;
  logic [1:0] STATE;

  timer_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .BTN_START_STOP (BTN_START_STOP),
    .BTN_CLEAR      (BTN_CLEAR),
    .TIMER_EXPIRED  (TIMER_EXPIRED),
    .RUN            (RUN),
    .CLR            (CLR),
    .ALARM          (ALARM),
    .STATE          (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 0;
  int clr_seen = 0;

  // Expected {STATE, RUN, ALARM, CLR} after each edge
  logic [4:0] exp_q[$];

  // Reference model state
  bit       hs[$];
  bit       hc[$];
  bit [1:0] m_acc, m_prev, m_press;
  bit [1:0] m_state;
  bit       m_clr;

  // A button is accepted once the last D samples all differ from the accepted level
  function automatic bit all_differ(bit q[$], bit lvl);
    if (q.size() < D) return 1'b0;
    foreach (q[j]) if (q[j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(bit rst, bit bs, bit bc, bit te);
    bit p_s, p_c;
    if (!rst) begin
      hs.delete();
      hc.delete();
      m_acc = '0; m_prev = '0; m_press = '0;
      m_state = 2'b00; m_clr = 1'b0;
    end else begin
      p_s = m_press[0];
      p_c = m_press[1];
      m_press = m_acc & ~m_prev;
      m_prev  = m_acc;
      hs.push_back(bs);
      if (hs.size() > D) void'(hs.pop_front());
      hc.push_back(bc);
      if (hc.size() > D) void'(hc.pop_front());
      if (all_differ(hs, m_acc[0])) m_acc[0] = bs;
      if (all_differ(hc, m_acc[1])) m_acc[1] = bc;
      m_clr = 1'b0;
      case (m_state)
        2'b00: if (p_c) m_clr = 1'b1; else if (p_s) m_state = 2'b01;
        2'b01: begin
          if (te) m_state = 2'b11;
          else if (p_c) begin m_state = 2'b00; m_clr = 1'b1; end
          else if (p_s) m_state = 2'b10;
        end
        2'b10: begin
          if (p_c) begin m_state = 2'b00; m_clr = 1'b1; end
          else if (p_s) m_state = 2'b01;
        end
        default: if (p_c || p_s) begin m_state = 2'b00; m_clr = 1'b1; end
      endcase
    end
    exp_q.push_back({m_state, m_state == 2'b01, m_state == 2'b11, m_clr});
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int outs();
    return int'({STATE, RUN, ALARM, CLR});
  endfunction

  // One clock: drive inputs, let the edge happen, record the model's prediction
  task automatic tick(bit rst, bit bs, bit bc, bit te);
    RST_N = rst;
    BTN_START_STOP = bs;
    BTN_CLEAR = bc;
    TIMER_EXPIRED = te;
    @(posedge CLK);
    model_step(rst, bs, bc, te);
    #2;
  endtask

  task automatic hold(bit bs, bit bc, int n);
    repeat (n) tick(1'b1, bs, bc, 1'b0);
  endtask

  task automatic press(bit bs, bit bc);
    clr_seen = 0;
    repeat (D) begin tick(1'b1, bs, bc, 1'b0); clr_seen += int'(CLR); end
    repeat (8) begin tick(1'b1, 1'b0, 1'b0, 1'b0); clr_seen += int'(CLR); end
  endtask

  // Monitor: every edge the DUT presents a new output word
  initial begin
    logic [4:0] e, a;
    forever begin
      @(posedge CLK);
      #1;
      if (done) break;
      n_checks++;
      a = {STATE, RUN, ALARM, CLR};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got %b with no prediction at %0t", a, $time);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_outputs: got {STATE,RUN,ALARM,CLR}=%b expected %b at %0t", a, e, $time);
        end
      end
    end
  end

  initial begin
    int  seg;
    bit  rbs, rbc;
    RST_N = 1'b0;
    BTN_START_STOP = 1'b1;
    BTN_CLEAR = 1'b0;
    TIMER_EXPIRED = 1'b0;

    repeat (10) tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("reset_outputs", outs(), 5'b00000);
    repeat (5) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("start_after_5_edges", outs(), 5'b00000);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("start_after_6_edges", outs(), 5'b01100);
    hold(1'b1, 1'b0, 8);
    check("held_single_event", outs(), 5'b01100);
    hold(1'b0, 1'b0, 8);

    press(1'b0, 1'b1);
    check("clear_to_idle", outs(), 5'b00000);
    check("clear_pulse_count", clr_seen, 1);

    hold(1'b1, 1'b0, D - 1);
    hold(1'b0, 1'b0, 8);
    check("glitch_rejected", outs(), 5'b00000);
    press(1'b1, 1'b0);
    check("min_pulse_runs", outs(), 5'b01100);
    press(1'b1, 1'b0);
    check("pause", outs(), 5'b10000);
    press(1'b1, 1'b0);
    check("resume", outs(), 5'b01100);
    press(1'b0, 1'b1);
    check("run_clear", outs(), 5'b00000);
    check("run_clear_pulse", clr_seen, 1);

    press(1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("expire_1_edge", outs(), 5'b11010);
    hold(1'b0, 1'b0, 3);
    press(1'b1, 1'b0);
    check("expired_start_idle", outs(), 5'b00000);
    check("expired_clr_pulse", clr_seen, 1);

    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check("both_press_clear_wins", outs(), 5'b00000);
    check("both_press_clr", clr_seen, 1);

    press(1'b1, 1'b0);
    clr_seen = 0;
    for (int t = 0; t < 12; t++) begin
      tick(1'b1, 1'b0, t < D, t == D + 1);
      clr_seen += int'(CLR);
    end
    check("expiry_beats_clear", outs(), 5'b11010);
    check("expiry_beats_clear_noclr", clr_seen, 0);
    press(1'b0, 1'b1);

    press(1'b1, 1'b0);
    check("run_before_reset", outs(), 5'b01100);
    hold(1'b1, 1'b0, 2);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("midrun_reset", outs(), 5'b00000);
    repeat (5) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_reset_no_early_event", outs(), 5'b00000);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_reset_full_debounce", outs(), 5'b01100);
    hold(1'b0, 1'b0, 8);

    seg = 0;
    for (int t = 0; t < 3000; t++) begin
      if (seg == 0) begin
        rbs = 1'($urandom_range(0, 1));
        rbc = ($urandom_range(0, 3) == 0);
        seg = int'($urandom_range(1, 8));
      end
      seg--;
      tick(!($urandom_range(0, 299) == 0), rbs, rbc, $urandom_range(0, 7) == 0);
    end

    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Run/pause/clear controller for the timer datapath. Consumes the two button levels after they leave the synchronizer instances, debounces each, and turns their presses into one-cycle events. A 4-state FSM uses those events plus TIMER_EXPIRED from the counter to drive the counter enable (RUN), a clear strobe (CLR) and an alarm flag. Sits between the input synchronizers and the timer counter/display logic.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles a raw level must differ from the accepted level before it is accepted (legal range 2..2^CNT_W-1)
CNT_W, 20, width of each debounce counter

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  synchronous active-low reset
BTN_START_STOP  in  1  synchronized start/stop button level, active high
BTN_CLEAR  in  1  synchronized clear button level, active high
TIMER_EXPIRED  in  1  counter reached terminal value, level, active high
RUN  out  1  counter enable; high only in RUNNING
CLR  out  1  one-cycle counter clear strobe
ALARM  out  1  high only in EXPIRED
STATE  out  2  current FSM state: IDLE=00, RUNNING=01, PAUSED=10, EXPIRED=11

Behaviour:
- Reset (RST_N=0 sampled on a rising edge): STATE=IDLE, RUN=0, CLR=0, ALARM=0, both accepted levels=0, both debounce counters=0, press strobes=0. Reset has priority over everything and may be applied mid-debounce or mid-run; it discards any partial count.
- Debounce, per button, identical logic:
  - raw==accepted: counter<=0.
  - raw!=accepted and counter<DEBOUNCE_CYCLES-1: counter<=counter+1.
  - raw!=accepted and counter==DEBOUNCE_CYCLES-1: accepted<=raw, counter<=0.
  - Result: accepted toggles on the DEBOUNCE_CYCLES-th consecutive edge that samples the differing level. Any glitch shorter than that leaves accepted unchanged.
  - Counter saturates by construction and never wraps.
- Press strobe: press_q<=accepted & ~accepted_prev, registered. It is high for exactly one cycle per accepted rising edge. Release generates no event.
- FSM: evaluated on each edge using press_q values and the current TIMER_EXPIRED.
  - IDLE: clear press -> stay IDLE, CLR pulse. Otherwise start press -> RUNNING.
  - RUNNING: TIMER_EXPIRED -> EXPIRED. This has the highest priority in RUNNING, above any simultaneous press. Otherwise clear press -> IDLE + CLR pulse. Otherwise start press -> PAUSED.
  - PAUSED: clear press -> IDLE + CLR pulse. Otherwise start press -> RUNNING. TIMER_EXPIRED is ignored.
  - EXPIRED: start or clear press -> IDLE + CLR pulse.
  - Simultaneous start+clear presses: clear wins in every state.
  - TIMER_EXPIRED in IDLE or PAUSED: no effect.
- Outputs:
  - RUN, ALARM and STATE are registered decodes of the next state, so they change on the same edge as the state register.
  - CLR is registered, high for exactly the one cycle following the edge that took the clear decision. It is never high two consecutive cycles.
- Latency: a clean step on a button input that is first sampled at edge k gives accepted high after edge k+DEBOUNCE_CYCLES-1, press_q high after edge k+DEBOUNCE_CYCLES, and the STATE/RUN/CLR update after edge k+DEBOUNCE_CYCLES+1.
- Latency from TIMER_EXPIRED high (RUNNING) to STATE=EXPIRED, RUN=0, ALARM=1: 1 edge.
- Holding a button produces exactly one event. A new event needs a debounced release followed by a debounced press.

Test Plan:
- Reset with DEBOUNCE_CYCLES=4, RST_N=0 for 10 cycles, BTN_START_STOP=1 held throughout -> STATE=00, RUN=0, CLR=0, ALARM=0 during reset. After RST_N=1, RUN=1 exactly 6 edges after release (4 debounce + strobe + FSM), with a single event only.
- Glitch rejection: BTN_START_STOP high for 3 cycles, then low, from IDLE -> STATE stays 00, no CLR. A 4-cycle pulse -> STATE=01.
- Full cycle: press start -> RUNNING (RUN=1). Press start -> PAUSED (RUN=0, STATE=10). Press start -> RUNNING. Press clear -> STATE=00, CLR high exactly 1 cycle.
- Expiry: in RUNNING drive TIMER_EXPIRED=1 -> next edge STATE=11, RUN=0, ALARM=1. Then press start -> STATE=00, ALARM=0, CLR pulse.
- Priority: start and clear strobes on the same cycle in RUNNING -> IDLE + CLR. TIMER_EXPIRED and clear strobe on the same cycle in RUNNING -> EXPIRED, no CLR.
- Mid-operation reset: in RUNNING with a partial debounce count of 2, assert RST_N=0 for 1 cycle -> all outputs reset. The button must then be stable for the full 4 cycles before any event.
